spi_flash_responder: RTL and testbench

//  Synthesizable SPI flash target (mode 0, single-IO) answering the flash controller's accesses.

---
 rtl/spi_flash_responder_pkg.sv | 30 +++
 rtl/spi_flash_responder_sync.sv | 38 +++
 rtl/spi_flash_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_responder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : spi_flash_pkg                                           |
// | Brief  : Shared opcodes, address width and FSM state encoding    |
// |          for the SPI flash responder.                            |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package spi_flash_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WAKE  = 8'hAB;
    localparam logic [7:0] OP_RESET = 8'hFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_e;

    // Byte address successor; wraps 0xFFFFFF -> 0x000000 by width.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_responder_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : spi_in_sync                                             |
// | Brief  : N-stage synchronizer with one-cycle rise/fall strobes.  |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the asynchronous input through the chain and keep the last value for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = ~r_prev &  r_sync[STAGES-1];
    assign o_fall =  r_prev & ~r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : spi_flash_responder                                     |
// | Brief  : SPI mode-0 flash target; decodes READ + 24-bit address, |
// |          fetches bytes from a memory port and shifts them out    |
// |          MSB-first, all logic oversampled in the clk_i domain.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_clk_i,
    input  logic              csb_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic              underrun_o
);

    // Synchronized SPI inputs
    logic w_sclk_lvl_unused;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_csb;
    logic w_csb_rise_unused;
    logic w_csb_fall;
    logic w_mosi;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_d    (spi_clk_i),
        .o_q    (w_sclk_lvl_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // csb resets deasserted so release of reset never fakes a select edge.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_d    (csb_i),
        .o_q    (w_csb),
        .o_rise (w_csb_rise_unused),
        .o_fall (w_csb_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_d    (mosi_i),
        .o_q    (w_mosi),
        .o_rise (w_mosi_rise_unused),
        .o_fall (w_mosi_fall_unused)
    );

    // State and datapath registers
    state_e            r_state;
    state_e            w_state_next;
    logic [4:0]        r_bit_cnt;
    logic [ADDR_W-1:0] r_shift_in;
    logic [7:0]        r_tx_shift;
    logic [2:0]        r_tx_cnt;
    logic              r_miso;
    logic              r_underrun;
    logic              r_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_pf_data;
    logic              r_pf_valid;
    logic              r_discard;
    logic              r_want;
    logic [ADDR_W-1:0] r_want_addr;
    logic [ADDR_W-1:0] r_next_addr;

    logic [ADDR_W-1:0] w_shift_word;
    logic              w_addr_done;
    logic              w_boundary;
    logic              w_load_pf;
    logic [7:0]        w_load_byte;
    logic              w_fetch_want;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;

    // Decode strobes for address completion, byte boundaries and fetch issue.
    always_comb begin
        w_shift_word = {r_shift_in[ADDR_W-2:0], w_mosi};
        w_addr_done  = (r_state == ADDR) && !w_csb && w_sclk_rise && (r_bit_cnt == 5'd23);
        w_boundary   = (r_state == DATA) && !w_csb && w_sclk_fall && (r_tx_cnt == 3'd0);
        w_load_pf    = w_boundary && r_pf_valid;
        // A missing prefetch is replaced by all-ones; the fetch stays outstanding.
        w_load_byte  = r_pf_valid ? r_pf_data : 8'hFF;
        w_fetch_want = w_addr_done || w_load_pf;
        w_fetch_addr = w_addr_done ? w_shift_word : r_next_addr;
        // Only one fetch in flight, so a new one waits for any earlier ack.
        w_issue      = !w_csb && !r_req && (w_fetch_want || r_want);
        w_issue_addr = w_fetch_want ? w_fetch_addr : r_want_addr;
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: deselect wins from any state, otherwise follow the command framing.
    always_comb begin
        w_state_next = r_state;
        if (w_csb) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_csb_fall) w_state_next = CMD;
                end
                CMD: begin
                    if (w_sclk_rise && (r_bit_cnt == 5'd7)) begin
                        case (w_shift_word[7:0])
                            OP_READ:           w_state_next = ADDR;
                            OP_WAKE, OP_RESET: w_state_next = IGNORE;
                            default:           w_state_next = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (w_sclk_rise && (r_bit_cnt == 5'd23)) w_state_next = DATA;
                end
                DATA:    w_state_next = DATA;
                IGNORE:  w_state_next = IGNORE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Shift opcode and address bits in on synchronized spi_clk rises.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt  <= 5'd0;
            r_shift_in <= '0;
        end else if (w_csb_fall) begin
            r_bit_cnt <= 5'd0;
        end else if (!w_csb && w_sclk_rise && ((r_state == CMD) || (r_state == ADDR))) begin
            r_shift_in <= w_shift_word;
            // The counter restarts between the opcode and the address field.
            r_bit_cnt  <= ((r_state == CMD) && (r_bit_cnt == 5'd7)) ? 5'd0 : r_bit_cnt + 5'd1;
        end
    end

    // Drive miso on synchronized spi_clk falls and track underruns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_shift <= 8'd0;
            r_tx_cnt   <= 3'd0;
            r_miso     <= MISO_IDLE;
            r_underrun <= 1'b0;
        end else begin
            if (w_csb_fall) r_underrun <= 1'b0;
            if (w_addr_done) r_tx_cnt <= 3'd0;
            if (w_csb || (r_state != DATA)) begin
                r_miso <= MISO_IDLE;
            end else if (w_sclk_fall) begin
                if (r_tx_cnt == 3'd0) begin
                    r_miso     <= w_load_byte[7];
                    r_tx_shift <= {w_load_byte[6:0], 1'b0};
                    r_tx_cnt   <= 3'd7;
                    if (!r_pf_valid) r_underrun <= 1'b1;
                end else begin
                    r_miso     <= r_tx_shift[7];
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    r_tx_cnt   <= r_tx_cnt - 3'd1;
                end
            end
        end
    end

    // Fetch handshake, prefetch buffer and next-address tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req       <= 1'b0;
            r_mem_addr  <= '0;
            r_pf_data   <= 8'd0;
            r_pf_valid  <= 1'b0;
            r_discard   <= 1'b0;
            r_want      <= 1'b0;
            r_want_addr <= '0;
            r_next_addr <= '0;
        end else begin
            if (w_addr_done) begin
                r_next_addr <= addr_inc(w_shift_word);
            end else if (w_load_pf) begin
                r_next_addr <= addr_inc(r_next_addr);
            end

            if (w_load_pf) r_pf_valid <= 1'b0;

            if (r_req && mem_ack_i) begin
                r_req     <= 1'b0;
                r_discard <= 1'b0;
                if (!r_discard) begin
                    r_pf_data  <= mem_rdata_i;
                    r_pf_valid <= 1'b1;
                end
            end

            if (w_issue) begin
                r_req      <= 1'b1;
                r_mem_addr <= w_issue_addr;
                r_want     <= 1'b0;
            end else if (w_fetch_want) begin
                r_want      <= 1'b1;
                r_want_addr <= w_fetch_addr;
            end

            // Deselect drops buffered data; an in-flight fetch runs to its ack and is thrown away.
            if (w_csb) begin
                r_pf_valid <= 1'b0;
                r_want     <= 1'b0;
                if (r_req && !mem_ack_i) r_discard <= 1'b1;
            end
        end
    end

    assign miso_o     = r_miso;
    assign mem_req_o  = r_req;
    assign mem_addr_o = r_mem_addr;
    assign busy_o     = ~w_csb;
    assign underrun_o = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_spi_flash_responder                                  |
// | Brief  : Self-checking bench: SPI controller, memory responder   |
// |          and a byte-addressed memory reference model.            |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_spi_flash_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        csb = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;
    logic        busy;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem_arr [logic [23:0]];
    logic [23:0] fetch_q [$];
    logic [7:0]  rx_q [$];
    logic        idle_ok;
    logic        busy_seen;
    bit          slow_mem = 1'b0;
    int          cur_lat = 0;
    int          lat_cnt = 0;

    always #5 clk = ~clk;

    spi_flash_responder #(.SYNC_STAGES(2), .MISO_IDLE(1'b0)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi_clk_i   (sclk),
        .csb_i       (csb),
        .mosi_i      (mosi),
        .miso_o      (miso),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy),
        .underrun_o  (underrun)
    );

    // Memory contents: explicit writes, else a fixed address hash.
    function automatic logic [7:0] mem_val(input logic [23:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Memory responder: one-cycle ack after a randomized (or long) latency.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                lat_cnt = 0;
            end else if (mem_req) begin
                if (lat_cnt >= cur_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_val(mem_addr);
                    fetch_q.push_back(mem_addr);
                    lat_cnt   = 0;
                    cur_lat   = slow_mem ? 200 : int'($urandom_range(0, 3));
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic spi_half();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic xfer_bit(input logic b, output logic rb);
        mosi = b;
        spi_half();
        rb = miso;
        busy_seen = busy_seen & busy;
        sclk = 1'b1;
        spi_half();
        sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [23:0] addr,
                             input int addr_bits, input int nbytes);
        logic       rb;
        logic [7:0] byte_v;
        rx_q.delete();
        idle_ok   = 1'b1;
        busy_seen = 1'b1;
        sclk = 1'b0;
        csb  = 1'b0;
        spi_half();
        for (int i = 0; i < 8; i++) begin
            xfer_bit(op[7-i], rb);
            if (rb !== 1'b0) idle_ok = 1'b0;
        end
        for (int i = 0; i < addr_bits; i++) begin
            xfer_bit(addr[23-i], rb);
            if (rb !== 1'b0) idle_ok = 1'b0;
        end
        for (int k = 0; k < nbytes; k++) begin
            byte_v = 8'd0;
            for (int j = 0; j < 8; j++) begin
                xfer_bit(1'b0, rb);
                byte_v = {byte_v[6:0], rb};
            end
            rx_q.push_back(byte_v);
        end
        spi_half();
        csb = 1'b1;
        repeat (4) spi_half();
    endtask

    task automatic test_reset();
        csb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sclk = ~sclk;
            repeat (3) @(posedge clk);
            #1;
            n_checks++;
            if ({miso, mem_req, busy, underrun, mem_addr} !== 28'd0) begin
                n_errors++;
                $display("FAIL reset_hold: got %h expected 0", {miso, mem_req, busy, underrun, mem_addr});
            end
        end
        sclk = 1'b0;
        csb  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({miso, mem_req, busy, underrun} !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected 0000", {miso, mem_req, busy, underrun});
        end
    endtask

    task automatic test_read_basic();
        logic [7:0] exp_b [4];
        exp_b = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        for (int i = 0; i < 4; i++) mem_arr[24'h10 + 24'(i)] = exp_b[i];
        run_frame(8'h03, 24'h000010, 24, 4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_q[i] !== exp_b[i]) begin
                n_errors++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
            end
        end
        n_checks++;
        if ({underrun, idle_ok, busy_seen, busy} !== 4'b0110) begin
            n_errors++;
            $display("FAIL basic_flags: got urun/idle/busyin/busyout %b expected 0110",
                     {underrun, idle_ok, busy_seen, busy});
        end
    endtask

    task automatic test_wrap();
        logic [23:0] a;
        fetch_q.delete();
        run_frame(8'h03, 24'hFFFFFE, 24, 3);
        n_checks++;
        if (fetch_q.size() < 3) begin
            n_errors++;
            $display("FAIL wrap_fetch_count: got %0d expected >=3", fetch_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            a = 24'hFFFFFE + 24'(i);
            n_checks++;
            if (rx_q[i] !== mem_val(a)) begin
                n_errors++;
                $display("FAIL wrap_byte%0d: got %h expected %h", i, rx_q[i], mem_val(a));
            end
            if (fetch_q.size() > i) begin
                n_checks++;
                if (fetch_q[i] !== a) begin
                    n_errors++;
                    $display("FAIL wrap_fetch%0d: got %h expected %h", i, fetch_q[i], a);
                end
            end
        end
    endtask

    task automatic test_ignored_ops();
        logic [7:0] ops [2];
        logic       zero;
        ops = '{8'hAB, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            fetch_q.delete();
            run_frame(ops[k], 24'h123456, 24, 2);
            zero = idle_ok;
            foreach (rx_q[i]) if (rx_q[i] !== 8'd0) zero = 1'b0;
            n_checks++;
            if (zero !== 1'b1) begin
                n_errors++;
                $display("FAIL ignore_miso_%h: got non-idle miso expected idle", ops[k]);
            end
            n_checks++;
            if (fetch_q.size() != 0) begin
                n_errors++;
                $display("FAIL ignore_fetch_%h: got %0d fetches expected 0", ops[k], fetch_q.size());
            end
        end
        run_frame(8'h03, 24'h000000, 24, 3);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rx_q[i] !== mem_val(24'(i))) begin
                n_errors++;
                $display("FAIL after_ignore_byte%0d: got %h expected %h", i, rx_q[i], mem_val(24'(i)));
            end
        end
    endtask

    task automatic test_underrun();
        slow_mem = 1'b1;
        cur_lat  = 200;
        run_frame(8'h03, 24'h000040, 24, 2);
        n_checks++;
        if (rx_q[0] !== 8'hFF) begin
            n_errors++;
            $display("FAIL underrun_byte: got %h expected ff", rx_q[0]);
        end
        n_checks++;
        if (underrun !== 1'b1) begin
            n_errors++;
            $display("FAIL underrun_flag: got %b expected 1", underrun);
        end
        repeat (250) @(posedge clk);
        slow_mem = 1'b0;
        cur_lat  = 0;
        #1;
        csb = 1'b0;
        repeat (2) spi_half();
        n_checks++;
        if (underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL underrun_clear: got %b expected 0", underrun);
        end
        csb = 1'b1;
        repeat (2) spi_half();
        run_frame(8'h03, 24'h000050, 24, 2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rx_q[i] !== mem_val(24'h50 + 24'(i))) begin
                n_errors++;
                $display("FAIL post_underrun_byte%0d: got %h expected %h", i, rx_q[i], mem_val(24'h50 + 24'(i)));
            end
        end
    endtask

    task automatic test_abort();
        fetch_q.delete();
        run_frame(8'h03, 24'h000100, 12, 0);
        n_checks++;
        if (fetch_q.size() != 0) begin
            n_errors++;
            $display("FAIL abort_fetch: got %0d fetches expected 0", fetch_q.size());
        end
        run_frame(8'h03, 24'h000100, 24, 1);
        n_checks++;
        if (rx_q[0] !== mem_val(24'h100)) begin
            n_errors++;
            $display("FAIL abort_next_byte: got %h expected %h", rx_q[0], mem_val(24'h100));
        end
        n_checks++;
        if (fetch_q.size() == 0 || fetch_q[0] !== 24'h000100) begin
            n_errors++;
            $display("FAIL abort_next_addr: got %0d entries expected first 000100", fetch_q.size());
        end
    endtask

    task automatic test_random();
        logic [23:0] base;
        logic [23:0] a;
        int          n;
        for (int t = 0; t < 10; t++) begin
            base = 24'($urandom);
            if (t % 3 == 0) base = 24'hFFFFFF - 24'($urandom_range(0, 3));
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) mem_arr[base + 24'(i)] = 8'($urandom);
            run_frame(8'h03, base, 24, n);
            for (int i = 0; i < n; i++) begin
                a = base + 24'(i);
                n_checks++;
                if (rx_q[i] !== mem_val(a)) begin
                    n_errors++;
                    $display("FAIL rand%0d_byte%0d: got %h expected %h", t, i, rx_q[i], mem_val(a));
                end
            end
            n_checks++;
            if (underrun !== 1'b0) begin
                n_errors++;
                $display("FAIL rand%0d_underrun: got %b expected 0", t, underrun);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic        rb;
        logic [31:0] hdr;
        hdr = {8'h03, 24'h000200};
        csb = 1'b0;
        spi_half();
        for (int i = 0; i < 36; i++) xfer_bit((i < 32) ? hdr[31-i] : 1'b0, rb);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({miso, mem_req, busy, underrun, mem_addr} !== 28'd0) begin
            n_errors++;
            $display("FAIL reset_mid: got %h expected 0", {miso, mem_req, busy, underrun, mem_addr});
        end
        repeat (3) @(posedge clk);
        #1;
        csb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) spi_half();
        run_frame(8'h03, 24'h000200, 24, 2);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rx_q[i] !== mem_val(24'h200 + 24'(i))) begin
                n_errors++;
                $display("FAIL reset_recover_byte%0d: got %h expected %h", i, rx_q[i], mem_val(24'h200 + 24'(i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_wrap();
        test_ignored_ops();
        test_underrun();
        test_abort();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
